// File: rtl/reagent_dose_sequencer.sv
// Dose / incubate / flush sequencer for an N-inlet mixing chip with per-channel lengths and abort.
// Optional macro SEQ_PAUSE_EN adds a pause input that freezes the sequence with all drives low.
module reagent_dose_sequencer #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16,
  localparam int CC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef SEQ_PAUSE_EN
  input  logic                    pause,
`endif
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*CNT_W-1:0] dose_len,
  input  logic [CNT_W-1:0]        incubate_len,
  input  logic [CNT_W-1:0]        flush_len,
  output logic [NUM_CH-1:0]       valve_open,
  output logic                    mix_pump,
  output logic                    out_valve,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [CC_W-1:0]         cur_ch
);

  // Phases 0..NUM_CH-1 are dose channels, NUM_CH is incubate, NUM_CH+1 is flush.
  localparam int NUM_PH = NUM_CH + 2;
  localparam int PH_W   = $clog2(NUM_PH + 1);

  typedef enum logic [2:0] {S_IDLE, S_DOSE, S_INCUBATE, S_FLUSH, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0]       sh_en;
  logic [NUM_CH*CNT_W-1:0] sh_dose;
  logic [CNT_W-1:0]        sh_inc, sh_fl;

  logic [NUM_CH-1:0]       en_src;
  logic [NUM_CH*CNT_W-1:0] dose_src;
  logic [CNT_W-1:0]        inc_src, fl_src;

  logic                    shadow_load, load, consume, hold_d;
  int                      from_ph, nxt_ph;
  logic [NUM_CH-1:0]       valve_d;
  logic                    mix_d, out_d, busy_d, done_d, aborted_d;
  logic [CC_W-1:0]         cur_ch_d;

  function automatic logic [CNT_W-1:0] phase_len(
    input int                      p,
    input logic [NUM_CH-1:0]       en,
    input logic [NUM_CH*CNT_W-1:0] dose,
    input logic [CNT_W-1:0]        inc,
    input logic [CNT_W-1:0]        fl
  );
    logic [CNT_W-1:0] len;
    len = '0;
    if (p < NUM_CH) begin
      if (en[p]) len = dose[p*CNT_W +: CNT_W];
    end else if (p == NUM_CH) begin
      len = inc;
    end else if (p == NUM_CH + 1) begin
      len = fl;
    end
    return len;
  endfunction

  // Lowest active phase at or above 'from'; NUM_PH means nothing is left to run.
  function automatic int first_active(
    input int                      from,
    input logic [NUM_CH-1:0]       en,
    input logic [NUM_CH*CNT_W-1:0] dose,
    input logic [CNT_W-1:0]        inc,
    input logic [CNT_W-1:0]        fl
  );
    int res;
    res = NUM_PH;
    for (int p = NUM_PH - 1; p >= 0; p--) begin
      if (p >= from && phase_len(p, en, dose, inc, fl) != '0) res = p;
    end
    return res;
  endfunction

  // On the accepting edge the shadows are not yet loaded, so look ahead on the live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      en_src   = ch_enable;
      dose_src = dose_len;
      inc_src  = incubate_len;
      fl_src   = flush_len;
    end else begin
      en_src   = sh_en;
      dose_src = sh_dose;
      inc_src  = sh_inc;
      fl_src   = sh_fl;
    end
  end

`ifdef SEQ_PAUSE_EN
  logic paused_q;
  // A cycle shown with drives forced low does not consume length.
  assign consume = !paused_q;
`else
  assign consume = 1'b1;
`endif

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    shadow_load = 1'b0;
    load        = 1'b0;
    from_ph     = 0;
    nxt_ph      = NUM_PH;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          shadow_load = 1'b1;
          load        = 1'b1;
        end
      end
      S_DOSE, S_INCUBATE, S_FLUSH, S_DONE: begin
        if (abort) begin
          state_d   = S_IDLE;
          ph_d      = '0;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else if (consume) begin
          if (cnt_q == '0) begin
            load    = 1'b1;
            from_ph = int'(ph_q) + 1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      nxt_ph = first_active(from_ph, en_src, dose_src, inc_src, fl_src);
      if (nxt_ph >= NUM_PH) begin
        state_d = S_DONE;
        ph_d    = '0;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        ph_d    = PH_W'(nxt_ph);
        cnt_d   = phase_len(nxt_ph, en_src, dose_src, inc_src, fl_src) - CNT_W'(1);
        if (nxt_ph < NUM_CH)       state_d = S_DOSE;
        else if (nxt_ph == NUM_CH) state_d = S_INCUBATE;
        else                       state_d = S_FLUSH;
      end
    end
  end

  assign busy_d = (state_d == S_DOSE) || (state_d == S_INCUBATE) || (state_d == S_FLUSH);
`ifdef SEQ_PAUSE_EN
  assign hold_d = pause && busy_d;
`else
  assign hold_d = 1'b0;
`endif

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    valve_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      valve_d[i] = (state_d == S_DOSE) && !hold_d && (ph_d == PH_W'(i));
    end
    mix_d    = (state_d == S_INCUBATE) && !hold_d;
    out_d    = (state_d == S_FLUSH) && !hold_d;
    cur_ch_d = (state_d == S_DOSE) ? ph_d[CC_W-1:0] : '0;
  end

  // NOTE: shadow registers are plain flops, not a memory, so they take the reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      cnt_q      <= '0;
      sh_en      <= '0;
      sh_dose    <= '0;
      sh_inc     <= '0;
      sh_fl      <= '0;
      valve_open <= '0;
      mix_pump   <= 1'b0;
      out_valve  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cur_ch     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      valve_open <= valve_d;
      mix_pump   <= mix_d;
      out_valve  <= out_d;
      busy       <= busy_d;
      done       <= done_d;
      aborted    <= aborted_d;
      cur_ch     <= cur_ch_d;
      if (shadow_load) begin
        sh_en   <= ch_enable;
        sh_dose <= dose_len;
        sh_inc  <= incubate_len;
        sh_fl   <= flush_len;
      end
    end
  end

`ifdef SEQ_PAUSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) paused_q <= 1'b0;
    else        paused_q <= hold_d;
  end
`endif

endmodule
